// File: rtl/phy_tx_scheduler_pkg.sv
// Shared types for the PHY transmit scheduler: FSM state encoding and data word width.
package phy_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    StTrain,
    StArb,
    StGrant
  } state_e;

  localparam int unsigned WordW = 32;

endpackage

// File: rtl/phy_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_owner, wrapping modulo NUM_REQ.
module phy_tx_scheduler_rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_owner,
  output logic               any_req,
  output logic [ID_W-1:0]    next_owner
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  int unsigned          pos;

  always_comb begin
    req_dbl = {req, req};
    // rot[j] is requester (last_owner + 1 + j) mod NUM_REQ
    rot     = NUM_REQ'(req_dbl >> (32'(last_owner) + 32'd1));
    any_req = |rot;
    pos     = 32'(last_owner);
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        pos = 32'(last_owner) + 32'd1 + 32'(j);
      end
    end
    if (pos >= NUM_REQ) begin
      pos = pos - NUM_REQ;
    end
    next_owner = ID_W'(pos);
  end

endmodule

// File: rtl/phy_tx_scheduler.sv
// Round-robin sharing of the PHY transmit input between requesters, gated by link training.
module phy_tx_scheduler
  import phy_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ID_W         = 1,
  parameter int unsigned MAX_BURST    = 4,
  parameter int unsigned TRAIN_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WordW-1:0] req_data,
  output logic [NUM_REQ-1:0]       ack,
  input  logic                     rx_sync,
  output logic [WordW-1:0]         phy_input_bus,
  output logic                     phy_valid,
  output logic                     link_up,
  output logic [ID_W-1:0]          owner_id
);

  localparam logic [7:0]      TrainMax  = 8'(TRAIN_CYCLES);
  localparam logic [3:0]      BurstLast = 4'(MAX_BURST - 1);
  localparam logic [ID_W-1:0] LastReset = ID_W'(NUM_REQ - 1);

  state_e            state_q, state_d;
  logic [7:0]        train_cnt_q, train_cnt_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic [ID_W-1:0]   last_owner_q, last_owner_d;
  logic [ID_W-1:0]   owner_id_q, owner_id_d;
  logic [WordW-1:0]  bus_q, bus_d;
  logic              valid_q, valid_d;
  logic              link_q, link_d;

  logic              any_req;
  logic [ID_W-1:0]   next_owner;
  logic              accept;
  logic [WordW-1:0]  owner_word;

  phy_tx_scheduler_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req        (req),
    .last_owner (last_owner_q),
    .any_req    (any_req),
    .next_owner (next_owner)
  );

  assign owner_word = req_data[32'(owner_id_q) * WordW +: WordW];
  // Sync loss masks the ack so the word stays with its requester for the retry.
  assign accept = !reset && (state_q == StGrant) && req[owner_id_q] && rx_sync;

  always_comb begin
    ack             = '0;
    ack[owner_id_q] = accept;
  end

  always_comb begin
    state_d      = state_q;
    train_cnt_d  = train_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    owner_id_d   = owner_id_q;
    bus_d        = bus_q;
    valid_d      = 1'b0;

    unique case (state_q)
      StTrain: begin
        if (train_cnt_q != TrainMax) begin
          train_cnt_d = train_cnt_q + 8'd1;
        end
        if (train_cnt_q == TrainMax && rx_sync) begin
          state_d = StArb;
        end
      end
      StArb: begin
        if (!rx_sync) begin
          state_d     = StTrain;
          train_cnt_d = '0;
        end else if (any_req) begin
          state_d     = StGrant;
          owner_id_d  = next_owner;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        if (!rx_sync) begin
          state_d     = StTrain;
          train_cnt_d = '0;
        end else begin
          if (accept) begin
            bus_d   = owner_word;
            valid_d = 1'b1;
            if (burst_cnt_q != 4'hF) begin
              burst_cnt_d = burst_cnt_q + 4'd1;
            end
          end
          if (!req[owner_id_q] || (accept && burst_cnt_q == BurstLast)) begin
            state_d      = StArb;
            last_owner_d = owner_id_q;
          end
        end
      end
      default: begin
        state_d     = StTrain;
        train_cnt_d = '0;
      end
    endcase

    link_d = (state_d != StTrain);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StTrain;
      train_cnt_q  <= '0;
      burst_cnt_q  <= '0;
      last_owner_q <= LastReset;
      owner_id_q   <= '0;
      bus_q        <= '0;
      valid_q      <= 1'b0;
      link_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      train_cnt_q  <= train_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      last_owner_q <= last_owner_d;
      owner_id_q   <= owner_id_d;
      bus_q        <= bus_d;
      valid_q      <= valid_d;
      link_q       <= link_d;
    end
  end

  assign phy_input_bus = bus_q;
  assign phy_valid     = valid_q;
  assign link_up       = link_q;
  assign owner_id      = owner_id_q;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Scoreboard bench for phy_tx_scheduler: directed bring-up/burst/resync scenarios plus random traffic.
module tb_phy_tx_scheduler;

  localparam int unsigned NUM_REQ      = 2;
  localparam int unsigned ID_W         = 1;
  localparam int unsigned MAX_BURST    = 4;
  localparam int unsigned TRAIN_CYCLES = 16;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*32-1:0]   req_data;
  logic [NUM_REQ-1:0]      ack;
  logic                    rx_sync;
  logic [31:0]             phy_input_bus;
  logic                    phy_valid;
  logic                    link_up;
  logic [ID_W-1:0]         owner_id;

  always #5 clk = ~clk;

  phy_tx_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .MAX_BURST    (MAX_BURST),
    .TRAIN_CYCLES (TRAIN_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req           (req),
    .req_data      (req_data),
    .ack           (ack),
    .rx_sync       (rx_sync),
    .phy_input_bus (phy_input_bus),
    .phy_valid     (phy_valid),
    .link_up       (link_up),
    .owner_id      (owner_id)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_q[$];

  // Reference model: link trained? owner holding the bus? words sent in this tenure.
  int          m_train;
  bit          m_linked;
  bit          m_granted;
  int          m_owner;
  int          m_last;
  int          m_burst;
  logic [31:0] m_bus;
  bit          exp_valid;
  bit          model_ready = 1'b0;

  // Requester stimulus state
  bit          en  [NUM_REQ];
  int          cnt [NUM_REQ];
  int          lim [NUM_REQ];
  logic [31:0] base[NUM_REQ];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(output logic [NUM_REQ-1:0] a);
    logic [31:0] w;
    a         = '0;
    exp_valid = 1'b0;
    if (reset) begin
      m_train   = 0;
      m_linked  = 1'b0;
      m_granted = 1'b0;
      m_owner   = 0;
      m_last    = NUM_REQ - 1;
      m_burst   = 0;
      m_bus     = '0;
    end else if (!m_linked) begin
      if (m_train >= TRAIN_CYCLES && rx_sync) begin
        m_linked  = 1'b1;
        m_granted = 1'b0;
      end else if (m_train < TRAIN_CYCLES) begin
        m_train++;
      end
    end else if (!rx_sync) begin
      m_linked  = 1'b0;
      m_granted = 1'b0;
      m_train   = 0;
    end else if (!m_granted) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int c;
        c = (m_last + k) % NUM_REQ;
        if (!m_granted && req[c]) begin
          m_granted = 1'b1;
          m_owner   = c;
          m_burst   = 0;
        end
      end
    end else begin
      if (req[m_owner]) begin
        w           = req_data[m_owner*32 +: 32];
        a[m_owner]  = 1'b1;
        exp_q.push_back(w);
        m_bus       = w;
        exp_valid   = 1'b1;
        m_burst++;
      end
      if (!req[m_owner] || m_burst == MAX_BURST) begin
        m_granted = 1'b0;
        m_last    = m_owner;
      end
    end
  endtask

  task automatic cyc(input int n);
    logic [NUM_REQ-1:0] a;
    logic [NUM_REQ-1:0] adv;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int r = 0; r < NUM_REQ; r++) begin
        req[r]               = en[r] && (cnt[r] <= lim[r]);
        req_data[r*32 +: 32] = base[r] + 32'(cnt[r]);
      end
      #1;
      model_eval(a);
      model_ready = 1'b1;
      check("ack", 32'(ack), 32'(a));
      adv = ack;
      @(posedge clk);
      #2;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (adv[r]) cnt[r]++;
      end
    end
  endtask

  task automatic set_req(input int r, input bit e, input logic [31:0] b, input int l);
    en[r]   = e;
    base[r] = b;
    cnt[r]  = 1;
    lim[r]  = l;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  initial begin
    logic [31:0] w;
    forever begin
      @(posedge clk);
      #1;
      if (model_ready) begin
        check("link_up", 32'(link_up), 32'(m_linked));
        check("owner_id", 32'(owner_id), 32'(m_owner));
        check("phy_valid", 32'(phy_valid), 32'(exp_valid));
        if (phy_valid) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got %h, expected no word at %0t", phy_input_bus, $time);
          end else begin
            w = exp_q.pop_front();
            check("phy_data", phy_input_bus, w);
          end
        end else begin
          check("bus_hold", phy_input_bus, m_bus);
          if (exp_valid && exp_q.size() != 0) w = exp_q.pop_front();
        end
      end
    end
  end

  initial begin
    int guard;
    reset    = 1'b1;
    rx_sync  = 1'b1;
    req      = '0;
    req_data = '0;
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b0, 32'h0, 0);

    // Bring-up with sync present
    cyc(3);
    reset = 1'b0;
    cyc(22);

    // Sync absent until cycle 40
    reset = 1'b1;
    cyc(3);
    reset   = 1'b0;
    rx_sync = 1'b0;
    cyc(40);
    rx_sync = 1'b1;
    cyc(4);

    // Single streamer, 8 words: two bursts with an ARB gap
    set_req(0, 1'b1, 32'h0, 8);
    cyc(16);
    set_req(0, 1'b0, 32'h0, 0);
    cyc(2);

    // Two always-on requesters from a fresh link
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(TRAIN_CYCLES + 2);
    set_req(0, 1'b1, 32'hA000_0000, 1000);
    set_req(1, 1'b1, 32'hB000_0000, 1000);
    cyc(16);
    set_req(0, 1'b0, 32'h0, 0);
    set_req(1, 1'b0, 32'h0, 0);
    cyc(3);

    // Sync loss after two words of requester 1
    set_req(1, 1'b1, 32'hC000_0000, 6);
    guard = 0;
    while (cnt[1] != 3 && guard < 30) begin
      cyc(1);
      guard++;
    end
    check("resync_setup", 32'(cnt[1]), 32'd3);
    rx_sync = 1'b0;
    cyc(2);
    rx_sync = 1'b1;
    cyc(TRAIN_CYCLES + 12);
    check("resync_words_sent", 32'(cnt[1]), 32'd7);
    set_req(1, 1'b0, 32'h0, 0);
    cyc(2);

    // Reset while granted
    set_req(0, 1'b1, 32'hD000_0000, 1000);
    set_req(1, 1'b1, 32'hE000_0000, 1000);
    guard = 0;
    while (cnt[0] != 3 && guard < 30) begin
      cyc(1);
      guard++;
    end
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    cyc(TRAIN_CYCLES + 8);

    // Random traffic, sync drops and occasional reset
    for (int i = 0; i < 1500; i++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if ($urandom_range(0, 9) == 0) en[r] = !en[r];
        if ($urandom_range(0, 199) == 0) base[r] = $urandom;
      end
      rx_sync = ($urandom_range(0, 99) != 0);
      reset   = ($urandom_range(0, 999) < 3);
      cyc(1);
    end
    reset   = 1'b0;
    rx_sync = 1'b1;
    for (int r = 0; r < NUM_REQ; r++) en[r] = 1'b0;
    cyc(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
